nv_nvdla_sdp_mrdma_ig_rd_req_split: RTL



---
 rtl/nv_nvdla_sdp_mrdma_ig_rd_req_split.sv | 111 +++++++++++
 1 files changed

// File: rtl/nv_nvdla_sdp_mrdma_ig_rd_req_split.sv
// Splits one MRDMA read request into burst-capped, alignment-safe DMA read chunks.
// Optional performance counters are enabled by defining SDP_MRDMA_RD_REQ_SPLIT_PERF_EN.
module nv_nvdla_sdp_mrdma_ig_rd_req_split #(
    parameter int MAX_BURST_ATOMS = 8,
    parameter int ALIGN_ATOMS     = 8
) (
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rst,
    input  logic        cv_int_rd_req_valid_d1,
    output logic        cv_int_rd_req_ready_d1,
    input  logic [78:0] cv_int_rd_req_pd_d1,
    output logic        dma_rd_req_valid,
    input  logic        dma_rd_req_ready,
    output logic [78:0] dma_rd_req_pd
`ifdef SDP_MRDMA_RD_REQ_SPLIT_PERF_EN
    ,
    input  logic        perf_clr,
    output logic [31:0] perf_req_cnt,
    output logic [31:0] perf_chunk_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    typedef enum logic {IDLE, SPLIT} state_t;

    state_t      state;
    logic [63:0] cur_addr;
    logic [15:0] remaining;

    // Atoms in the next chunk: limited by what is left, the burst cap and the next alignment boundary.
    function automatic logic [15:0] chunk_len(input logic [63:0] addr, input logic [15:0] rem);
        logic [63:0] offs;
        logic [63:0] to_bound;
        logic [63:0] len;
        offs     = (addr >> 5) & 64'(ALIGN_ATOMS - 1);
        to_bound = 64'(ALIGN_ATOMS) - offs;
        len      = {48'd0, rem};
        if (len > 64'(MAX_BURST_ATOMS)) len = 64'(MAX_BURST_ATOMS);
        if (len > to_bound) len = to_bound;
        return 16'(len);
    endfunction

    logic [15:0] cur_len;
    logic [63:0] nxt_addr;
    logic [15:0] nxt_rem;
    logic [15:0] nxt_len;
    logic [63:0] in_addr;
    logic [15:0] in_rem;
    logic [15:0] in_len;
    logic        fire;
    logic        last;
    logic        accept;

    assign cur_len  = {1'b0, dma_rd_req_pd[78:64]} + 16'd1;
    assign nxt_addr = cur_addr + (64'(cur_len) << 5);
    assign nxt_rem  = remaining - cur_len;
    assign nxt_len  = chunk_len(nxt_addr, nxt_rem);
    assign in_addr  = cv_int_rd_req_pd_d1[63:0];
    assign in_rem   = {1'b0, cv_int_rd_req_pd_d1[78:64]} + 16'd1;
    assign in_len   = chunk_len(in_addr, in_rem);

    assign fire   = dma_rd_req_valid && dma_rd_req_ready;
    assign last   = (nxt_rem == 16'd0);
    assign cv_int_rd_req_ready_d1 = (state == IDLE) || (fire && last);
    assign accept = cv_int_rd_req_valid_d1 && cv_int_rd_req_ready_d1;

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state            <= IDLE;
            dma_rd_req_valid <= 1'b0;
            dma_rd_req_pd    <= '0;
            cur_addr         <= '0;
            remaining        <= '0;
        end else if (accept) begin
            // A new request loads directly, even while the last chunk of the previous one retires.
            cur_addr         <= in_addr;
            remaining        <= in_rem;
            dma_rd_req_pd    <= {15'(in_len - 16'd1), in_addr};
            dma_rd_req_valid <= 1'b1;
            state            <= SPLIT;
        end else if (fire) begin
            cur_addr  <= nxt_addr;
            remaining <= nxt_rem;
            if (last) begin
                dma_rd_req_valid <= 1'b0;
                state            <= IDLE;
            end else begin
                dma_rd_req_pd <= {15'(nxt_len - 16'd1), nxt_addr};
            end
        end
    end

`ifdef SDP_MRDMA_RD_REQ_SPLIT_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
        return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    endfunction

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst || perf_clr) begin
            perf_req_cnt   <= '0;
            perf_chunk_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (accept) perf_req_cnt <= sat_inc(perf_req_cnt);
            if (fire) perf_chunk_cnt <= sat_inc(perf_chunk_cnt);
            if (dma_rd_req_valid && !dma_rd_req_ready) perf_stall_cnt <= sat_inc(perf_stall_cnt);
        end
    end
`endif

endmodule
